four_bit_up_counter: RTL and testbench
======================================

// Module: four_bit_up_counter
// PURPOSE
//  Registered up-counter; the incrementing counterpart of the decrementer datapath.
//  Next-state arithmetic uses a ripple half-adder incrementer (count + 1).
//  Counts modulo MAX+1, with enable, synchronous load and synchronous clear.
//  Provides a terminal-count flag, a one-cycle wrap pulse for cascading counters,
//  and a sticky overflow flag.
// PARAMETERS
//  WIDTH  4   counter width in bits
//  MAX    15  terminal value; count wraps MAX -> 0 (must satisfy 1 <= MAX <= 2**WIDTH-1)
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  clr        in   1      synchronous clear to 0
//  load       in   1      synchronous parallel load of din
//  din        in   WIDTH  load value
//  en         in   1      count enable
//  count      out  WIDTH  registered count value
//  tc         out  1      combinational terminal count: (count==MAX) & en
//  carry_out  out  1      registered one-cycle pulse, asserted the cycle after a wrap
//  ovf        out  1      sticky: set on the first wrap, held until clr or rst
// BEHAVIOUR
//  - Reset: rst=1 forces count=0, carry_out=0, ovf=0 immediately, independent of clk.
//    Reset mid-count discards state; counting resumes from 0 on the first edge after release.
//  - Priority at each rising edge: clr > load > en > hold.
//  - clr: count<=0, carry_out<=0, ovf<=0. Overrides load and en in the same cycle.
//  - load: count <= (din > MAX) ? MAX : din (clamped), carry_out<=0, ovf unchanged.
//    load+en in the same cycle: load wins; no increment in that cycle.
//  - en (no clr/load):
//    - count < MAX: count <= count+1 (incrementer sum, low WIDTH bits); carry_out<=0.
//    - count == MAX: count <= 0, carry_out<=1 for exactly one cycle, ovf<=1.
//  - Idle (en=0, no clr/load): count holds; carry_out<=0; ovf holds.
//  - Latency: count reflects en/load/clr one cycle after they are sampled.
//    tc is combinational, same cycle.
//    carry_out is high during the cycle in which count==0 after the wrap.
//  - Arithmetic: the incrementer produces WIDTH+1 bits {cout,sum}. cout is set only
//    for count==2**WIDTH-1. When MAX==2**WIDTH-1 the wrap coincides with cout;
//    otherwise the wrap is detected by compare against MAX, never by cout alone.
//  - Count values > MAX are unreachable; load clamps to MAX.
//  - Cascade: chaining tc of stage N into en of stage N+1 must yield a correct
//    multi-digit count with no extra cycle of latency.
// STRUCTURE
//  - Shared package: default WIDTH/MAX constants and the DECADE_MAX=9 constant.
//  - Sub-module: four_bit_incrementer (a[WIDTH-1:0] -> {cout,sum}), built as a
//    ripple chain of halfAdder cells with the carry-in tied to 1. It is the
//    add-one dual of the decrementer and reuses the existing NAND-based
//    halfAdder/xor_2In/and_2In cells.
//  - Top level: state register, priority mux, MAX comparator, clamp, carry_out/ovf flops.
// TESTING
//  1. rst=1 at any point -> count=0, carry_out=0, ovf=0 without a clock edge.
//     Release rst, en=0 for 3 clk -> count stays 0.
//  2. en=1 for 16 clk from 0 (MAX=15) -> count 1..15 then 0. tc=1 while count==15.
//     carry_out=1 only in the cycle count==0; ovf=1 from then on.
//  3. load=1, din=9 -> count=9. Then en=1 for 3 clk -> 12.
//     load=1 with en=1, din=4 -> count=4 (no increment).
//  4. MAX=9, WIDTH=4: en from 0 -> 9 then 0 with a carry_out pulse.
//     load din=13 -> count=9 (clamped).
//  5. count=7, ovf=1; assert clr, load, en together -> count=0, ovf=0, carry_out=0.
//  6. rst asserted mid-count (count=11) between edges -> immediate 0.
//     Two cascaded instances, 4 edges after 0xFF with tc->en -> 0x03.

Source files
------------

// File: rtl/four_bit_up_counter_pkg.sv
// Shared constants for the up-counter slice: default geometry and the decade terminal value.
package four_bit_up_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_MAX   = 15;
  localparam int DECADE_MAX    = 9;

  // True when the terminal value is the all-ones code, so the wrap coincides with the incrementer carry.
  function automatic bit is_full_range(input int width, input int max_val);
    return (max_val == ((2 ** width) - 1));
  endfunction

endpackage

// File: rtl/four_bit_up_counter_incrementer.sv
// Ripple add-one incrementer built from NAND-based half-adder cells; produces {cout, sum} = a + 1.
module xor_2In (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n1_s, n2_s, n3_s;

  assign n1_s = ~(a & b);
  assign n2_s = ~(a & n1_s);
  assign n3_s = ~(b & n1_s);
  assign y    = ~(n2_s & n3_s);
endmodule

module and_2In (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n1_s;

  assign n1_s = ~(a & b);
  assign y    = ~(n1_s & n1_s);
endmodule

module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  xor_2In u_xor (.a(a), .b(b), .y(s));
  and_2In u_and (.a(a), .b(b), .y(c));
endmodule

module four_bit_incrementer
  import four_bit_up_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // Carry-in of the first cell is tied high: that is the "+1".
  logic [WIDTH:0] carry_s;

  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    halfAdder u_ha (
      .a(a[i]),
      .b(carry_s[i]),
      .s(sum[i]),
      .c(carry_s[i+1])
    );
  end

  assign cout = carry_s[WIDTH];
endmodule

// File: rtl/four_bit_up_counter.sv
// Modulo-(MAX+1) up-counter with clear/load/enable priority, terminal count, wrap pulse and sticky overflow.
module four_bit_up_counter
  import four_bit_up_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MAX   = DEFAULT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry_out,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX);
  localparam bit               FULL_RANGE = is_full_range(WIDTH, MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] inc_sum_s;
  logic             inc_cout_s;
  logic             at_max_s;
  logic             wrap_s;
  logic [WIDTH-1:0] din_clamped_s;

  four_bit_incrementer #(.WIDTH(WIDTH)) u_inc (
    .a   (count_q),
    .sum (inc_sum_s),
    .cout(inc_cout_s)
  );

  // Terminal compare, wrap detect and load clamp.
  always_comb begin
    at_max_s = (count_q == MAX_V);
    // Short ranges must wrap on the compare; cout alone only fires at the all-ones code.
    if (FULL_RANGE) begin
      wrap_s = inc_cout_s;
    end else begin
      wrap_s = at_max_s;
    end
    if (din > MAX_V) begin
      din_clamped_s = MAX_V;
    end else begin
      din_clamped_s = din;
    end
  end

  // Next-state priority mux: clear, then load, then count, else hold.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = din_clamped_s;
    end else if (en) begin
      if (wrap_s) begin
        count_d = {WIDTH{1'b0}};
        carry_d = 1'b1;
        ovf_d   = 1'b1;
      end else begin
        count_d = inc_sum_s;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count     = count_q;
  assign tc        = at_max_s & en;
  assign carry_out = carry_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_four_bit_up_counter.sv
// Self-checking bench: vector table plus hand sequences, expectations queued at drive time and popped after the edge.
module tb_four_bit_up_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clr, load, en;
  logic [3:0] din;
  logic [3:0] count;
  logic       tc, carry_out, ovf;

  logic       clr9, load9, en9;
  logic [3:0] din9;
  logic [3:0] count9;
  logic       tc9, carry9, ovf9;

  logic       cas_clr, cas_load, cas_en;
  logic [3:0] cas_din;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, hi_tc, lo_carry, hi_carry, lo_ovf, hi_ovf;

  four_bit_up_counter #(.WIDTH(4), .MAX(15)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en),
    .count(count), .tc(tc), .carry_out(carry_out), .ovf(ovf)
  );

  four_bit_up_counter #(.WIDTH(4), .MAX(9)) dut9 (
    .clk(clk), .rst(rst), .clr(clr9), .load(load9), .din(din9), .en(en9),
    .count(count9), .tc(tc9), .carry_out(carry9), .ovf(ovf9)
  );

  four_bit_up_counter #(.WIDTH(4), .MAX(15)) u_lo (
    .clk(clk), .rst(rst), .clr(cas_clr), .load(cas_load), .din(cas_din), .en(cas_en),
    .count(lo_count), .tc(lo_tc), .carry_out(lo_carry), .ovf(lo_ovf)
  );

  four_bit_up_counter #(.WIDTH(4), .MAX(15)) u_hi (
    .clk(clk), .rst(rst), .clr(cas_clr), .load(cas_load), .din(cas_din), .en(lo_tc),
    .count(hi_count), .tc(hi_tc), .carry_out(hi_carry), .ovf(hi_ovf)
  );

  typedef struct packed {
    logic [3:0] count;
    logic       carry;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic [3:0] din;
    logic       exp_tc;
    logic [3:0] exp_count;
    logic       exp_carry;
    logic       exp_ovf;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       exp9_q[$];
  logic [7:0] cas_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic e, input logic [3:0] d,
                      input logic etc, input logic [3:0] ec, input logic ecar, input logic eovf);
    exp_t x;
    @(negedge clk);
    clr = c; load = l; en = e; din = d;
    #1;
    check("tc", 32'(tc), 32'(etc));
    exp_q.push_back('{ec, ecar, eovf});
    @(posedge clk);
    #1;
    check("queue_depth", 32'(exp_q.size()), 32'd1);
    x = exp_q.pop_front();
    check("count", 32'(count), 32'(x.count));
    check("carry_out", 32'(carry_out), 32'(x.carry));
    check("ovf", 32'(ovf), 32'(x.ovf));
  endtask

  task automatic step9(input logic c, input logic l, input logic e, input logic [3:0] d,
                       input logic etc, input logic [3:0] ec, input logic ecar, input logic eovf);
    exp_t x;
    @(negedge clk);
    clr9 = c; load9 = l; en9 = e; din9 = d;
    #1;
    check("tc9", 32'(tc9), 32'(etc));
    exp9_q.push_back('{ec, ecar, eovf});
    @(posedge clk);
    #1;
    check("queue9_depth", 32'(exp9_q.size()), 32'd1);
    x = exp9_q.pop_front();
    check("count9", 32'(count9), 32'(x.count));
    check("carry9", 32'(carry9), 32'(x.carry));
    check("ovf9", 32'(ovf9), 32'(x.ovf));
  endtask

  vec_t vecs[14];
  logic [7:0] cas_exp;

  initial begin
    // Table starts from count=0, ovf=1 (state left by the 16-cycle run plus one idle cycle).
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'd9,  1'b0, 4'd9,  1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd10, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd11, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd12, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 4'd4,  1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 4'd15, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'd15, 1'b1, 4'd15, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 4'd0,  1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd7,  1'b0, 4'd7,  1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 4'd0,  1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd1,  1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd1,  1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0};

    rst = 1'b1;
    clr = 1'b0; load = 1'b0; en = 1'b0; din = 4'd0;
    clr9 = 1'b0; load9 = 1'b0; en9 = 1'b0; din9 = 4'd0;
    cas_clr = 1'b0; cas_load = 1'b0; cas_en = 1'b0; cas_din = 4'd0;

    // Reset state before any clock edge.
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after release: count stays 0.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Full run through the wrap.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 1'b1, 4'd0, (i == 15), 4'((i + 1) % 16), (i == 15), (i == 15));
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++)
      step(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].din,
           vecs[i].exp_tc, vecs[i].exp_count, vecs[i].exp_carry, vecs[i].exp_ovf);

    // Decade counter: 0..9, wrap, then clamped load.
    for (int i = 0; i < 10; i++)
      step9(1'b0, 1'b0, 1'b1, 4'd0, (i == 9), 4'((i + 1) % 10), (i == 9), (i == 9));
    step9(1'b0, 1'b1, 1'b0, 4'd13, 1'b0, 4'd9, 1'b0, 1'b1);
    step9(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1);
    step9(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Cascade: load 0xFF, then 4 edges with lo enabled.
    @(negedge clk);
    cas_load = 1'b1; cas_din = 4'd15;
    @(posedge clk);
    #1;
    check("cas_load", 32'({hi_count, lo_count}), 32'h0FF);
    @(negedge clk);
    cas_load = 1'b0; cas_en = 1'b1;
    #1;
    check("cas_lo_tc", 32'(lo_tc), 32'd1);
    check("cas_hi_tc", 32'(hi_tc), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      cas_q.push_back(8'(k));
      @(posedge clk);
      #1;
      check("cas_queue_depth", 32'(cas_q.size()), 32'd1);
      cas_exp = cas_q.pop_front();
      check("cas_count", 32'({hi_count, lo_count}), 32'(cas_exp));
    end
    @(negedge clk);
    cas_en = 1'b0;

    // Mid-count reset between edges clears everything immediately.
    step(1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 4'd15, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 4'd11, 1'b0, 1'b1);
    @(negedge clk);
    clr = 1'b0; load = 1'b0; en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
